// File: rtl/adv_timer_deadtime_gen.sv
`default_nettype none
// ============================================================================
// Module   : adv_timer_deadtime_gen
// Brief    : Complementary high/low-side PWM pairs with programmable dead time
//            and a global sticky fault shutdown.
// Revision : 1.0
// ============================================================================
module adv_timer_deadtime_gen #(
    parameter int N_CH     = 4,
    parameter int DT_WIDTH = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cfg_en_i,
    input  logic                cfg_update_i,
    input  logic [DT_WIDTH-1:0] cfg_dt_i,
    input  logic                cfg_clr_i,
    input  logic [N_CH-1:0]     pwm_i,
    input  logic                fault_i,
    output logic [N_CH-1:0]     pwm_hi_o,
    output logic [N_CH-1:0]     pwm_lo_o,
    output logic [N_CH-1:0]     dt_active_o,
    output logic                fault_o
);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_LO_ON = 3'd1,
        S_DT_HI = 3'd2,
        S_HI_ON = 3'd3,
        S_DT_LO = 3'd4,
        S_FLT   = 3'd5
    } state_t;

    localparam logic [DT_WIDTH-1:0] c_CNT_ONE = DT_WIDTH'(1);

    logic [DT_WIDTH-1:0] r_dt_q;
    logic                r_fault;
    logic                w_dt_zero;

    assign w_dt_zero = (r_dt_q == '0);
    assign fault_o   = r_fault;

    // A new dead-time value only affects later loads; running countdowns keep theirs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_dt_q  <= '0;
            r_fault <= 1'b0;
        end else begin
            if (cfg_update_i) begin
                r_dt_q <= cfg_dt_i;
            end
            if (fault_i) begin
                r_fault <= 1'b1;
            end else if (cfg_clr_i) begin
                r_fault <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        state_t              r_state;
        state_t              w_nxt_state;
        logic [DT_WIDTH-1:0] r_cnt;
        logic [DT_WIDTH-1:0] w_nxt_cnt;
        logic                r_hi;
        logic                r_lo;
        logic                r_dt;

        always_comb begin
            w_nxt_state = r_state;
            w_nxt_cnt   = r_cnt;
            if (fault_i) begin
                w_nxt_state = S_FLT;
            end else if (r_state == S_FLT) begin
                if (cfg_clr_i) begin
                    w_nxt_state = S_OFF;
                end
            end else if (!cfg_en_i) begin
                w_nxt_state = S_OFF;
            end else begin
                case (r_state)
                    S_OFF, S_LO_ON, S_HI_ON: begin
                        // Load dead time on entry or on a pwm edge seen in a steady state.
                        if (pwm_i[g] && (r_state != S_HI_ON)) begin
                            w_nxt_cnt   = r_dt_q;
                            w_nxt_state = w_dt_zero ? S_HI_ON : S_DT_HI;
                        end else if (!pwm_i[g] && (r_state != S_LO_ON)) begin
                            w_nxt_cnt   = r_dt_q;
                            w_nxt_state = w_dt_zero ? S_LO_ON : S_DT_LO;
                        end
                    end
                    S_DT_HI: begin
                        if (!pwm_i[g]) begin
                            w_nxt_state = S_LO_ON;
                        end else if (r_cnt == c_CNT_ONE) begin
                            w_nxt_state = S_HI_ON;
                        end else begin
                            w_nxt_cnt = r_cnt - c_CNT_ONE;
                        end
                    end
                    S_DT_LO: begin
                        if (pwm_i[g]) begin
                            w_nxt_state = S_HI_ON;
                        end else if (r_cnt == c_CNT_ONE) begin
                            w_nxt_state = S_LO_ON;
                        end else begin
                            w_nxt_cnt = r_cnt - c_CNT_ONE;
                        end
                    end
                    default: w_nxt_state = S_OFF;
                endcase
            end
        end

        // Outputs are registered from the next state so they line up with r_state.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_state <= S_OFF;
                r_cnt   <= '0;
                r_hi    <= 1'b0;
                r_lo    <= 1'b0;
                r_dt    <= 1'b0;
            end else begin
                r_state <= w_nxt_state;
                r_cnt   <= w_nxt_cnt;
                r_hi    <= (w_nxt_state == S_HI_ON);
                r_lo    <= (w_nxt_state == S_LO_ON);
                r_dt    <= (w_nxt_state == S_DT_HI) || (w_nxt_state == S_DT_LO);
            end
        end

        assign pwm_hi_o[g]    = r_hi;
        assign pwm_lo_o[g]    = r_lo;
        assign dt_active_o[g] = r_dt;
    end

endmodule
`default_nettype wire
